operand_fetch: RTL

//  Register-read stage of the 16-bit MIPS pipeline; read-side counterpart of the writeback stage.

---
 rtl/operand_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Register-read stage of the 16-bit MIPS pipeline. Holds the architectural
//   register file (one writeback write port, two decode read ports), tracks
//   in-flight destinations in a scoreboard so RAW/WAW hazards stall decode, and
//   hands registered operands to execute over a valid/ready handshake.
//
// Configuration macro:
//   BYPASS_EN  when defined, a writeback arriving this cycle is forwarded to the
//              operand read ports and releases a RAW stall in the same cycle.
//              When undefined, reads see stored contents only and a RAW stall
//              releases one cycle after the writeback.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   id_valid/id_ready   decode handshake
//   id_rs, id_rt        source A/B register addresses
//   id_rd, id_wr        destination address and its write flag
//   wb_en, wb_addr      writeback write enable and destination
//   ans_wb              writeback data
//   ex_valid/ex_ready   execute handshake
//   ex_op_a, ex_op_b    registered operands
//   ex_rd, ex_wr        destination and write flag passed down the pipe
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_wr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] ans_wb,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_wr
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [REG_N-1:0]  pending;
  logic [REG_N-1:0]  pending_next;
  logic [REG_N-1:0]  wb_hit;
  logic [REG_N-1:0]  blocked;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hazard;
  logic              accept;

  // One-hot view of the register being written back this cycle.
  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_addr] = 1'b1;
  end

  // Which source registers currently block a read. With forwarding, the
  // register whose result is arriving right now is no longer a hazard.
  always_comb begin
`ifdef BYPASS_EN
    blocked = pending & ~wb_hit;
`else
    blocked = pending;
`endif
  end

  // Operand read ports. R0 always reads zero regardless of storage or bypass.
  always_comb begin
    op_a = regs[id_rs];
    op_b = regs[id_rt];
`ifdef BYPASS_EN
    if (wb_hit[id_rs]) op_a = ans_wb;
    if (wb_hit[id_rt]) op_b = ans_wb;
`endif
    if (id_rs == '0) op_a = '0;
    if (id_rt == '0) op_b = '0;
  end

  // WAW uses the raw pending bit: a second writer to the same register waits
  // until the first writeback has fully retired from the scoreboard.
  always_comb begin
    hazard = ((id_rs != '0) && blocked[id_rs]) ||
             ((id_rt != '0) && blocked[id_rt]) ||
             (id_wr && (id_rd != '0) && pending[id_rd]);
    id_ready = (!ex_valid || ex_ready) && !hazard;
    accept   = id_valid && id_ready;
  end

  // Scoreboard update: writeback clears, a newly accepted writer sets, and the
  // set is applied last so it wins when both target the same register.
  always_comb begin
    pending_next = pending & ~wb_hit;
    if (accept && id_wr && (id_rd != '0)) pending_next[id_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Register file storage; writes to R0 are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= ans_wb;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  // Output register toward execute. Contents only change on accept, so they
  // stay stable while execute back-pressures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_rd    <= '0;
      ex_wr    <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op_a  <= op_a;
      ex_op_b  <= op_b;
      ex_rd    <= id_rd;
      ex_wr    <= id_wr;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
